// File: rtl/controlador_entrada_saida.sv
// User I/O sequencer: stalls the core on IN until a debounced ENTER press/release,
// captures OUT values, and freezes the processor on HALT.
module controlador_entrada_saida #(
    parameter int DATA_WIDTH      = 32,
    parameter int SW_WIDTH        = 16,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  isInsert,
    input  logic                  outWrite,
    input  logic                  isHalt,
    input  logic                  enterBtn,
    input  logic [SW_WIDTH-1:0]   switches,
    input  logic [DATA_WIDTH-1:0] outData,
    output logic                  isInput,
    output logic                  cpuEnable,
    output logic [DATA_WIDTH-1:0] inData,
    output logic [DATA_WIDTH-1:0] outReg,
    output logic                  outValid,
    output logic                  halted,
    output logic [2:0]            ioState
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        RUN          = 3'd0,
        WAIT_PRESS   = 3'd1,
        WAIT_RELEASE = 3'd2,
        COMMIT       = 3'd3,
        HALT         = 3'd4
    } state_t;

    state_t                state_q;
    logic                  sync1_q;
    logic                  sync2_q;
    logic                  db_level_q;
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         cnt_d;
    logic                  db_flip;
    logic                  press;
    logic                  release_evt;
    logic [DATA_WIDTH-1:0] in_data_q;
    logic [DATA_WIDTH-1:0] out_reg_q;
    logic                  out_valid_q;

    // A level is accepted once the synced input has disagreed with the
    // debounced level for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        db_flip     = (sync2_q != db_level_q) && (cnt_q == CNT_LAST);
        press       = db_flip & db_level_q;
        release_evt = db_flip & ~db_level_q;
        if ((sync2_q == db_level_q) || db_flip) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            db_level_q <= 1'b1;
            cnt_q      <= '0;
        end else begin
            sync1_q <= enterBtn;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            if (db_flip) begin
                db_level_q <= ~db_level_q;
            end
        end
    end

    always_comb begin
        isInput   = (state_q != COMMIT);
        cpuEnable = ((state_q == RUN) && !isHalt && !isInsert) || (state_q == COMMIT);
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            in_data_q   <= '0;
            out_reg_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= cpuEnable & outWrite;
            if (cpuEnable && outWrite) begin
                out_reg_q <= outData;
            end
            case (state_q)
                RUN: begin
                    if (isHalt) begin
                        state_q <= HALT;
                    end else if (isInsert) begin
                        state_q <= WAIT_PRESS;
                    end
                end
                WAIT_PRESS: begin
                    if (press) begin
                        state_q   <= WAIT_RELEASE;
                        in_data_q <= DATA_WIDTH'(switches);
                    end
                end
                WAIT_RELEASE: begin
                    if (release_evt) begin
                        state_q <= COMMIT;
                    end
                end
                COMMIT:  state_q <= RUN;
                HALT:    state_q <= HALT;
                default: state_q <= RUN;
            endcase
        end
    end

    assign inData   = in_data_q;
    assign outReg   = out_reg_q;
    assign outValid = out_valid_q;
    assign halted   = (state_q == HALT);
    assign ioState  = state_q;

endmodule

// File: tb/tb_controlador_entrada_saida.sv
// Directed bench for controlador_entrada_saida with DEBOUNCE_CYCLES=4.
module tb_controlador_entrada_saida;

    logic        clk;
    logic        rst;
    logic        isInsert;
    logic        outWrite;
    logic        isHalt;
    logic        enterBtn;
    logic [15:0] switches;
    logic [31:0] outData;
    logic        isInput;
    logic        cpuEnable;
    logic [31:0] inData;
    logic [31:0] outReg;
    logic        outValid;
    logic        halted;
    logic [2:0]  ioState;

    int passed = 0;
    int total  = 0;

    controlador_entrada_saida #(
        .DATA_WIDTH(32),
        .SW_WIDTH(16),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clock(clk),
        .rst(rst),
        .isInsert(isInsert),
        .outWrite(outWrite),
        .isHalt(isHalt),
        .enterBtn(enterBtn),
        .switches(switches),
        .outData(outData),
        .isInput(isInput),
        .cpuEnable(cpuEnable),
        .inData(inData),
        .outReg(outReg),
        .outValid(outValid),
        .halted(halted),
        .ioState(ioState)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        ins;
        logic        ow;
        logic        btn;
        logic [15:0] sw;
        logic [31:0] od;
        logic [2:0]  st;
        logic        cpu;
        logic        inp;
        logic [31:0] ind;
        logic [31:0] oreg;
        logic        oval;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(logic ins, logic ow, logic btn, logic [15:0] sw,
                                logic [31:0] od, logic [2:0] st, logic cpu, logic inp,
                                logic [31:0] ind, logic [31:0] oreg, logic oval);
        vec_t v;
        v.ins = ins; v.ow = ow; v.btn = btn; v.sw = sw; v.od = od;
        v.st = st; v.cpu = cpu; v.inp = inp; v.ind = ind; v.oreg = oreg; v.oval = oval;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            passed++;
            $display("ok   %s = %h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1'b0; isInsert = 1'b0; outWrite = 1'b0; isHalt = 1'b0;
        enterBtn = 1'b1; switches = 16'hA5A5; outData = 32'h0;

        // Reset state
        #2;
        chk("rst_state", 32'(ioState), 32'd0);
        chk("rst_cpuEnable", 32'(cpuEnable), 32'd1);
        chk("rst_isInput", 32'(isInput), 32'd1);
        chk("rst_inData", inData, 32'h0);
        chk("rst_outReg", outReg, 32'h0);
        chk("rst_outValid", 32'(outValid), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // OUT capture, IN flow with a clean 6-cycle press and release
        vecs[0] = mk(0, 1, 1, 16'hA5A5, 32'h1234, 3'd0, 1, 1, 32'h0, 32'h1234, 1);
        vecs[1] = mk(0, 0, 1, 16'hA5A5, 32'h0,    3'd0, 1, 1, 32'h0, 32'h1234, 0);
        vecs[2] = mk(1, 0, 1, 16'hA5A5, 32'h0,    3'd1, 0, 1, 32'h0, 32'h1234, 0);
        vecs[3] = mk(1, 1, 1, 16'hA5A5, 32'hFFFF, 3'd1, 0, 1, 32'h0, 32'h1234, 0);
        for (int i = 4; i < 9; i++)
            vecs[i] = mk(1, 0, 0, 16'hA5A5, 32'h0, 3'd1, 0, 1, 32'h0, 32'h1234, 0);
        vecs[9] = mk(1, 0, 0, 16'hA5A5, 32'h0, 3'd2, 0, 1, 32'h0000A5A5, 32'h1234, 0);
        for (int i = 10; i < 15; i++)
            vecs[i] = mk(1, 0, 1, 16'h1111, 32'h0, 3'd2, 0, 1, 32'h0000A5A5, 32'h1234, 0);
        vecs[15] = mk(1, 0, 1, 16'h1111, 32'h0, 3'd3, 1, 0, 32'h0000A5A5, 32'h1234, 0);
        vecs[16] = mk(0, 0, 1, 16'h1111, 32'h0, 3'd0, 1, 1, 32'h0000A5A5, 32'h1234, 0);
        vecs[17] = mk(0, 0, 1, 16'h1111, 32'h0, 3'd0, 1, 1, 32'h0000A5A5, 32'h1234, 0);

        for (int i = 0; i < 18; i++) begin
            isInsert = vecs[i].ins; outWrite = vecs[i].ow; enterBtn = vecs[i].btn;
            switches = vecs[i].sw;  outData  = vecs[i].od;
            step();
            chk($sformatf("v%0d_state", i), 32'(ioState), 32'(vecs[i].st));
            chk($sformatf("v%0d_cpuEnable", i), 32'(cpuEnable), 32'(vecs[i].cpu));
            chk($sformatf("v%0d_isInput", i), 32'(isInput), 32'(vecs[i].inp));
            chk($sformatf("v%0d_inData", i), inData, vecs[i].ind);
            chk($sformatf("v%0d_outReg", i), outReg, vecs[i].oreg);
            chk($sformatf("v%0d_outValid", i), 32'(outValid), 32'(vecs[i].oval));
            chk($sformatf("v%0d_halted", i), 32'(halted), 32'd0);
        end

        // Bounce in WAIT_PRESS: no press accepted
        isInsert = 1'b1; switches = 16'h7777;
        step();
        chk("bounce_enter", 32'(ioState), 32'd1);
        for (int i = 0; i < 20; i++) begin
            enterBtn = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
            step();
        end
        enterBtn = 1'b1;
        steps(4);
        chk("bounce_state", 32'(ioState), 32'd1);
        chk("bounce_inData", inData, 32'h0000A5A5);

        // Clean press then asynchronous reset mid-WAIT_RELEASE
        switches = 16'h5A5A; enterBtn = 1'b0;
        steps(5);
        chk("press5_state", 32'(ioState), 32'd1);
        step();
        chk("press6_state", 32'(ioState), 32'd2);
        chk("press6_inData", inData, 32'h00005A5A);
        #2;
        rst = 1'b0; isInsert = 1'b0; enterBtn = 1'b1;
        #1;
        chk("arst_state", 32'(ioState), 32'd0);
        chk("arst_inData", inData, 32'h0);
        chk("arst_outReg", outReg, 32'h0);
        chk("arst_cpuEnable", 32'(cpuEnable), 32'd1);
        @(negedge clk);
        rst = 1'b1;

        // HALT wins over IN; everything else ignored until reset
        isHalt = 1'b1; isInsert = 1'b1;
        #1;
        chk("halt_pre_cpuEnable", 32'(cpuEnable), 32'd0);
        step();
        chk("halt_state", 32'(ioState), 32'd4);
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_cpuEnable", 32'(cpuEnable), 32'd0);
        isHalt = 1'b0; outWrite = 1'b1; outData = 32'hDEAD; enterBtn = 1'b0;
        steps(8);
        enterBtn = 1'b1;
        steps(8);
        chk("halt_hold_state", 32'(ioState), 32'd4);
        chk("halt_hold_outReg", outReg, 32'h0);
        chk("halt_hold_outValid", 32'(outValid), 32'd0);
        chk("halt_hold_cpuEnable", 32'(cpuEnable), 32'd0);
        chk("halt_hold_inData", inData, 32'h0);
        #2;
        rst = 1'b0; isInsert = 1'b0; outWrite = 1'b0;
        #1;
        chk("halt_rst_state", 32'(ioState), 32'd0);
        chk("halt_rst_halted", 32'(halted), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Button already held before IN: needs release and a fresh press
        switches = 16'h3C3C; enterBtn = 1'b0;
        steps(8);
        isInsert = 1'b1;
        #1;
        chk("held_pre_cpuEnable", 32'(cpuEnable), 32'd0);
        step();
        chk("held_enter_state", 32'(ioState), 32'd1);
        steps(8);
        chk("held_state", 32'(ioState), 32'd1);
        chk("held_inData", inData, 32'h0);
        enterBtn = 1'b1;
        steps(8);
        chk("held_rel_state", 32'(ioState), 32'd1);
        chk("held_rel_inData", inData, 32'h0);
        switches = 16'hC3C3; enterBtn = 1'b0;
        steps(6);
        chk("held_press_state", 32'(ioState), 32'd2);
        chk("held_press_inData", inData, 32'h0000C3C3);
        enterBtn = 1'b1; switches = 16'h0F0F;
        steps(6);
        chk("held_commit_state", 32'(ioState), 32'd3);
        chk("held_commit_isInput", 32'(isInput), 32'd0);
        chk("held_commit_cpuEnable", 32'(cpuEnable), 32'd1);
        isInsert = 1'b0;
        step();
        chk("held_done_state", 32'(ioState), 32'd0);
        chk("held_done_inData", inData, 32'h0000C3C3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
